// File: rtl/vga_sync_rx_if.sv
// Signal bundle between a VGA timing source and the vga_sync_rx receiver.
// master drives the raw syncs, slave (the receiver) drives the decoded timing outputs.
interface vga_sync_rx_if;
  logic        hsync;
  logic        vsync;
  logic        de;
  logic [9:0]  x_pos;
  logic [9:0]  y_pos;
  logic        pixel_valid;
  logic        frame_start;
  logic [10:0] line_total;
  logic [10:0] frame_lines;
  logic        locked;
  logic        timing_err;
  logic [7:0]  err_cnt;

  modport master (
    output hsync, vsync, de,
    input  x_pos, y_pos, pixel_valid, frame_start, line_total, frame_lines,
    input  locked, timing_err, err_cnt
  );

  modport slave (
    input  hsync, vsync, de,
    output x_pos, y_pos, pixel_valid, frame_start, line_total, frame_lines,
    output locked, timing_err, err_cnt
  );
endinterface

// File: rtl/vga_sync_rx.sv
// VGA sync receiver: pixel addressing, line/frame length measurement, lock tracking.
// Define VGA_SYNC_RX_ERRCNT_EN to build the saturating timing-error counter.
module vga_sync_rx (
  input logic          clk,
  input logic          reset_n,
  vga_sync_rx_if.slave bus
);

  typedef enum logic [1:0] {StSearch, StMeasure, StLocked} state_e;

  state_e      state_q, state_d;
  logic        hs_s1, hs_s2, vs_s1, vs_s2, de_s1, de_s2;
  logic        hs_fall, vs_fall, de_fall;
  logic [9:0]  x_q, x_d, y_q, y_d;
  logic [10:0] period_q, period_d, lines_q, lines_d;
  logic [10:0] ref_q, line_total_q, frame_lines_q;
  logic        mismatch_q, frame_start_q, timing_err_q;
  logic        capture_ref, set_mismatch, lock_ok, err_det, locked;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hs_s1 <= 1'b1;
      hs_s2 <= 1'b1;
      vs_s1 <= 1'b1;
      vs_s2 <= 1'b1;
      de_s1 <= 1'b0;
      de_s2 <= 1'b0;
    end else begin
      hs_s1 <= bus.hsync;
      hs_s2 <= hs_s1;
      vs_s1 <= bus.vsync;
      vs_s2 <= vs_s1;
      de_s1 <= bus.de;
      de_s2 <= de_s1;
    end
  end

  assign hs_fall = hs_s2 & ~hs_s1;
  assign vs_fall = vs_s2 & ~vs_s1;
  assign de_fall = de_s2 & ~de_s1;

  always_comb begin
    x_d = x_q;
    if (de_fall) begin
      x_d = '0;
    end else if (de_s2 && (x_q != 10'd1023)) begin
      x_d = x_q + 10'd1;
    end

    // vsync fall wins over a coincident de fall
    y_d = y_q;
    if (vs_fall) begin
      y_d = '0;
    end else if (de_fall && (y_q != 10'd1023)) begin
      y_d = y_q + 10'd1;
    end

    period_d = period_q;
    if (hs_fall) begin
      period_d = 11'd1;
    end else if (period_q != 11'd2047) begin
      period_d = period_q + 11'd1;
    end

    lines_d = lines_q;
    if (vs_fall) begin
      lines_d = hs_fall ? 11'd1 : 11'd0;
    end else if (hs_fall && (lines_q != 11'd2047)) begin
      lines_d = lines_q + 11'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StSearch;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StSearch:  if (vs_fall) state_d = StMeasure;
      StMeasure: if (lock_ok) state_d = StLocked;
      StLocked:  if (err_det) state_d = StSearch;
      default:   state_d = StSearch;
    endcase
  end

  // lines_q == 1 on an hsync fall means this is the second fall since the vsync fall
  always_comb begin
    capture_ref  = 1'b0;
    set_mismatch = 1'b0;
    lock_ok      = 1'b0;
    err_det      = 1'b0;
    locked       = 1'b0;
    unique case (state_q)
      StMeasure: begin
        capture_ref  = hs_fall && (lines_q == 11'd1);
        set_mismatch = hs_fall && (lines_q >= 11'd2) && (period_q != ref_q);
        lock_ok      = vs_fall && !mismatch_q && !set_mismatch && (lines_q >= 11'd2);
      end
      StLocked: begin
        locked  = 1'b1;
        err_det = (hs_fall && (period_q != line_total_q)) ||
                  (vs_fall && (lines_q != frame_lines_q));
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      x_q           <= '0;
      y_q           <= '0;
      period_q      <= '0;
      lines_q       <= '0;
      ref_q         <= '0;
      mismatch_q    <= 1'b0;
      line_total_q  <= '0;
      frame_lines_q <= '0;
      frame_start_q <= 1'b0;
      timing_err_q  <= 1'b0;
    end else begin
      x_q      <= x_d;
      y_q      <= y_d;
      period_q <= period_d;
      lines_q  <= lines_d;
      if (capture_ref) ref_q <= period_q;
      if (vs_fall) begin
        mismatch_q <= 1'b0;
      end else if (set_mismatch) begin
        mismatch_q <= 1'b1;
      end
      if (lock_ok) begin
        line_total_q  <= ref_q;
        frame_lines_q <= lines_q;
      end
      frame_start_q <= vs_fall;
      timing_err_q  <= err_det;
    end
  end

`ifdef VGA_SYNC_RX_ERRCNT_EN
  logic [7:0] err_cnt_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      err_cnt_q <= '0;
    end else if (err_det && (err_cnt_q != 8'd255)) begin
      err_cnt_q <= err_cnt_q + 8'd1;
    end
  end

  assign bus.err_cnt = err_cnt_q;
`else
  assign bus.err_cnt = '0;
`endif

  assign bus.x_pos       = x_q;
  assign bus.y_pos       = y_q;
  assign bus.pixel_valid = de_s2;
  assign bus.frame_start = frame_start_q;
  assign bus.line_total  = line_total_q;
  assign bus.frame_lines = frame_lines_q;
  assign bus.locked      = locked;
  assign bus.timing_err  = timing_err_q;

endmodule

// File: tb/tb_vga_sync_rx.sv
// Scoreboard bench for vga_sync_rx: the driver queues expected pixels and pulses,
// a negedge monitor pops and compares them whenever the DUT presents one.
module tb_vga_sync_rx;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  vga_sync_rx_if bus ();

  vga_sync_rx dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  typedef struct packed {
    int unsigned cyc;
    logic [9:0]  x;
    logic [9:0]  y;
  } pix_t;

  pix_t        pix_q[$];
  int unsigned fs_q[$];
  int unsigned te_q[$];

  int          checks = 0;
  int          errors = 0;
  int unsigned cyc = 0;

  logic prev_h = 1'b1, prev_v = 1'b1, prev_d = 1'b0;
  int   exp_x = 0, exp_y = 0;
  int   ht, ha, hs0, hsl, vt, va, vs0, vsl;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, want, cyc);
    end
  endtask

  // One input vector per clock; expectations are timed at 2 clocks after the drive cycle.
  task automatic drive(input logic h, input logic v, input logic d, input bit e);
    pix_t p;
    bus.hsync = h;
    bus.vsync = v;
    bus.de    = d;
    if (d) begin
      if (!prev_d) exp_x = 0;
      p.cyc = cyc + 2;
      p.x   = exp_x[9:0];
      p.y   = exp_y[9:0];
      if (reset_n) pix_q.push_back(p);
      if (exp_x < 1023) exp_x++;
    end
    if (prev_v && !v) begin
      exp_y = 0;
      if (reset_n) fs_q.push_back(cyc + 2);
    end else if (prev_d && !d && exp_y < 1023) begin
      exp_y++;
    end
    if (e && reset_n) te_q.push_back(cyc + 2);
    prev_h = h;
    prev_v = v;
    prev_d = d;
    @(posedge clk);
    #1;
  endtask

  task automatic drive_frame(input int short_line, input int err_line, input int limit);
    int   n;
    int   len;
    logic h, v, d;
    n = 0;
    for (int vc = 0; vc < vt; vc++) begin
      len = (vc == short_line) ? ht - 1 : ht;
      for (int hc = 0; hc < len; hc++) begin
        if (limit >= 0 && n == limit) return;
        h = !(hc >= hs0 && hc < hs0 + hsl);
        v = !(vc >= vs0 && vc < vs0 + vsl);
        d = (hc < ha) && (vc < va);
        drive(h, v, d, (vc == err_line) && (hc == hs0));
        n++;
      end
    end
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    pix_q.delete();
    fs_q.delete();
    te_q.delete();
    prev_h = 1'b1;
    prev_v = 1'b1;
    prev_d = 1'b0;
    exp_x  = 0;
    exp_y  = 0;
    repeat (3) drive(1'b1, 1'b1, 1'b0, 1'b0);
    reset_n = 1'b1;
    drive(1'b1, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_x_pos"}, 32'(bus.x_pos), 0);
    chk({tag, "_y_pos"}, 32'(bus.y_pos), 0);
    chk({tag, "_pixel_valid"}, 32'(bus.pixel_valid), 0);
    chk({tag, "_frame_start"}, 32'(bus.frame_start), 0);
    chk({tag, "_line_total"}, 32'(bus.line_total), 0);
    chk({tag, "_frame_lines"}, 32'(bus.frame_lines), 0);
    chk({tag, "_locked"}, 32'(bus.locked), 0);
    chk({tag, "_timing_err"}, 32'(bus.timing_err), 0);
    chk({tag, "_err_cnt"}, 32'(bus.err_cnt), 0);
  endtask

  always @(negedge clk) begin : monitor
    pix_t p;
    int unsigned t;
    if (!reset_n) begin
      chk("reset_quiet", 32'({bus.pixel_valid, bus.frame_start, bus.timing_err}), 0);
    end else begin
      if (bus.pixel_valid) begin
        if (pix_q.size() == 0) begin
          chk("pixel_unexpected", 32'(bus.pixel_valid), 0);
        end else begin
          p = pix_q.pop_front();
          chk("pixel_cycle", cyc, p.cyc);
          chk("x_pos", 32'(bus.x_pos), 32'(p.x));
          chk("y_pos", 32'(bus.y_pos), 32'(p.y));
        end
      end
      if (bus.frame_start) begin
        if (fs_q.size() == 0) begin
          chk("frame_start_unexpected", 32'(bus.frame_start), 0);
        end else begin
          t = fs_q.pop_front();
          chk("frame_start_cycle", cyc, t);
        end
      end
      if (bus.timing_err) begin
        if (te_q.size() == 0) begin
          chk("timing_err_unexpected", 32'(bus.timing_err), 0);
        end else begin
          t = te_q.pop_front();
          chk("timing_err_cycle", cyc, t);
        end
      end
    end
  end

  initial begin
    bus.hsync = 1'b1;
    bus.vsync = 1'b1;
    bus.de    = 1'b0;
    ht = 100; ha = 64; hs0 = 68; hsl = 12;
    vt = 16;  va = 10; vs0 = 12; vsl = 2;

    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    reset_n = 1'b1;
    repeat (2) drive(1'b1, 1'b1, 1'b0, 1'b0);

    // Long de run: x_pos must stop at 1023
    repeat (1030) drive(1'b1, 1'b1, 1'b1, 1'b0);
    repeat (4) drive(1'b1, 1'b1, 1'b0, 1'b0);

    drive_frame(-1, -1, -1);
    chk("locked_after_1st_vsync", 32'(bus.locked), 0);
    drive_frame(-1, -1, -1);
    chk("locked_after_2nd_vsync", 32'(bus.locked), 1);
    chk("line_total", 32'(bus.line_total), 100);
    chk("frame_lines", 32'(bus.frame_lines), 16);
    drive_frame(-1, -1, -1);
    chk("locked_3rd_frame", 32'(bus.locked), 1);

    // Line 3 one clock short: error reported at the hsync fall ending it
    drive_frame(3, 4, -1);
    chk("locked_after_short_line", 32'(bus.locked), 0);
`ifdef VGA_SYNC_RX_ERRCNT_EN
    chk("err_cnt_after_short_line", 32'(bus.err_cnt), 1);
`else
    chk("err_cnt_after_short_line", 32'(bus.err_cnt), 0);
`endif
    chk("line_total_held", 32'(bus.line_total), 100);
    drive_frame(-1, -1, -1);
    drive_frame(-1, -1, -1);
    chk("relocked", 32'(bus.locked), 1);
    chk("relock_frame_lines", 32'(bus.frame_lines), 16);

    // Asynchronous reset in the middle of an active line
    drive_frame(-1, -1, 3 * ht + 10);
    chk("pre_reset_locked", 32'(bus.locked), 1);
    chk("pre_reset_pixel_valid", 32'(bus.pixel_valid), 1);
    #2;
    reset_n = 1'b0;
    #1;
    check_all_zero("mid_reset");
    do_reset();
    drive_frame(-1, -1, -1);
    drive_frame(-1, -1, -1);
    chk("locked_after_reset", 32'(bus.locked), 1);
    chk("frame_lines_after_reset", 32'(bus.frame_lines), 16);

    // de fall and vsync fall in the same cycle
    do_reset();
    repeat (5) drive(1'b1, 1'b1, 1'b1, 1'b0);
    repeat (3) drive(1'b1, 1'b1, 1'b0, 1'b0);
    repeat (5) drive(1'b1, 1'b1, 1'b1, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk("coincident_frame_start", 32'(bus.frame_start), 1);
    chk("coincident_y_pos", 32'(bus.y_pos), 0);
    @(negedge clk);
    chk("frame_start_one_cycle", 32'(bus.frame_start), 0);
    repeat (2) drive(1'b1, 1'b1, 1'b0, 1'b0);
    repeat (3) drive(1'b1, 1'b1, 1'b1, 1'b0);
    repeat (3) drive(1'b1, 1'b1, 1'b0, 1'b0);

`ifdef VGA_SYNC_RX_ERRCNT_EN
    // 300 forced errors on a tiny 8x4 timing; counter must saturate
    do_reset();
    ht = 8; ha = 4; hs0 = 5; hsl = 1;
    vt = 4; va = 2; vs0 = 3; vsl = 1;
    drive_frame(-1, -1, -1);
    drive_frame(-1, -1, -1);
    chk("tiny_locked", 32'(bus.locked), 1);
    for (int i = 0; i < 300; i++) begin
      drive_frame(1, 2, -1);
      drive_frame(-1, -1, -1);
    end
    chk("err_cnt_saturated", 32'(bus.err_cnt), 255);
    chk("tiny_relocked", 32'(bus.locked), 1);
`endif

    repeat (5) drive(1'b1, 1'b1, 1'b0, 1'b0);
    chk("pixels_outstanding", 32'(pix_q.size()), 0);
    chk("frame_starts_outstanding", 32'(fs_q.size()), 0);
    chk("timing_errs_outstanding", 32'(te_q.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
